instr_decode_seq: RTL and testbench

- Parametrised, registered instruction-decode stage for the CPU core.
- Sits between instruction fetch and the register file / ALU.
- Accepts one instruction per cycle over a valid/ready handshake and assembles 2-part literals in an internal register.
- Stalls on memory ops until acknowledged, emits a decoded control packet downstream, and halts on the `done` function.

---
 rtl/instr_decode_seq.sv | 85 ++++++++
 tb/tb_instr_decode_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_seq.sv
// instr_decode_seq: registered decode stage with literal assembly, memory stall and halt; DECODE_ILLEGAL_TRAP_EN traps zzzz
module instr_decode_seq #(
  parameter int IW  = 9,
  parameter int OPW = 5,
  parameter int RW  = IW - OPW,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] op,
  output logic [RW-1:0]  reg_sel,
  output logic [DW-1:0]  lit_val,
  output logic           mov_en,
  output logic           br_en,
  output logic           math_en,
  output logic           mem_rd,
  output logic           mem_wr,
  input  logic           mem_ack,
  output logic           halted,
  output logic           illegal
);
  typedef enum logic [1:0] {RUN, MEM, HALT} state_t;
  state_t state, state_n;
  logic [OPW-1:0] iop;
  logic [RW-1:0] iopd;
  logic accept, is_mem, is_done, is_ill;
  assign iop = instr[IW-1:IW-OPW];
  assign iopd = instr[RW-1:0];
  assign accept = in_valid && in_ready;
  assign is_mem = iop == OPW'(16) || iop == OPW'(17);
  assign is_done = iop == OPW'(31) && iopd[1:0] == 2'd3;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign is_ill = iop == OPW'(24);
`else
  assign is_ill = 1'b0;
`endif
  assign in_ready = !reset && state == RUN && (!out_valid || out_ready);
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == RUN && accept) state_n = is_mem ? MEM : (is_done || is_ill) ? HALT : RUN;
    else if (state == MEM && mem_ack) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      op <= '0;
      reg_sel <= '0;
      lit_val <= '0;
      mov_en <= 1'b0;
      br_en <= 1'b0;
      math_en <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      op <= iop;
      reg_sel <= iopd;
      mov_en <= iop >= OPW'(2) && iop <= OPW'(15);
      br_en <= iop >= OPW'(20) && iop <= OPW'(23);
      math_en <= iop == OPW'(26) || iop == OPW'(27);
      if (iop == OPW'(0)) lit_val[RW-1:0] <= iopd;
      if (iop == OPW'(1)) lit_val[DW-1:RW] <= iopd[DW-RW-1:0];
      mem_rd <= iop == OPW'(16);
      mem_wr <= iop == OPW'(17);
      out_valid <= !is_mem && !is_ill;
      halted <= is_done || is_ill;
      illegal <= is_ill;
    end else if (state == MEM && mem_ack) begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      out_valid <= 1'b1;
    end else if (out_ready && state != MEM) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_decode_seq.sv
// tb_instr_decode_seq: directed stimulus with a packet scoreboard for instr_decode_seq
module tb_instr_decode_seq;
  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rs;
    logic [7:0] lit;
    logic mov, br, math;
  } pkt_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, mem_ack = 0;
  logic [8:0] instr = '0;
  logic in_ready, out_valid, mov_en, br_en, math_en, mem_rd, mem_wr, halted, illegal;
  logic [4:0] op;
  logic [3:0] reg_sel;
  logic [7:0] lit_val;
  logic [7:0] mlit = '0;
  pkt_t sb[$];
  pkt_t e;
  int checks = 0, errors = 0;
  instr_decode_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .reg_sel(reg_sel), .lit_val(lit_val),
    .mov_en(mov_en), .br_en(br_en), .math_en(math_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ack(mem_ack), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic pkt_t mk(input logic [4:0] o, input logic [3:0] r);
    return '{o, r, mlit, o >= 2 && o <= 15, o >= 20 && o <= 23, o == 26 || o == 27};
  endfunction
  task automatic model_lit(input logic [4:0] o, input logic [3:0] r);
    if (o == 0) mlit[3:0] = r;
    if (o == 1) mlit[7:4] = r;
  endtask
  task automatic issue(input logic [4:0] o, input logic [3:0] r, input bit pkt);
    int n = 0;
    instr = {o, r};
    in_valid = 1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1);
    model_lit(o, r);
    if (pkt) sb.push_back(mk(o, r));
    tick();
    in_valid = 0;
  endtask
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pkt observed=op%0d expected=none", op);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pkt", {12'h0, op, reg_sel, lit_val, mov_en, br_en, math_en}, {12'h0, e});
      end
    end
  initial begin
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lit", lit_val, 0);
    chk("rst_halted", halted, 0);
    reset = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    issue(5'd6, 4'd5, 1);
    chk("movx_valid", out_valid, 1);
    chk("movx_op", op, 6);
    chk("movx_reg", reg_sel, 5);
    chk("movx_mov", mov_en, 1);
    chk("movx_in_ready", in_ready, 1);
    issue(5'd0, 4'hA, 1);
    chk("litl_val", lit_val, 8'h0A);
    issue(5'd1, 4'h3, 1);
    chk("lith_val", lit_val, 8'h3A);
    chk("lith_valid", out_valid, 1);
    issue(5'd16, 4'd2, 1);
    for (int i = 0; i < 3; i++) begin
      chk("load_rd", mem_rd, 1);
      chk("load_in_ready", in_ready, 0);
      chk("load_no_valid", out_valid, 0);
      if (i == 2) mem_ack = 1;
      else tick();
    end
    tick();
    mem_ack = 0;
    chk("load_rd_drop", mem_rd, 0);
    chk("load_valid", out_valid, 1);
    chk("load_op", op, 16);
    issue(5'd19, 4'd1, 1);
    chk("incr_op", op, 19);
    issue(5'd17, 4'd7, 1);
    chk("stor_wr", mem_wr, 1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("stor_wr_drop", mem_wr, 0);
    chk("stor_valid", out_valid, 1);
    mem_ack = 1;
    issue(5'd3, 4'd1, 1);
    mem_ack = 0;
    chk("ack_ignored_rd", mem_rd, 0);
    out_ready = 0;
    instr = {5'd20, 4'd4};
    in_valid = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_op", op, 3);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("release_in_ready", in_ready, 1);
    model_lit(5'd20, 4'd4);
    sb.push_back(mk(5'd20, 4'd4));
    tick();
    in_valid = 0;
    chk("jizr_op", op, 20);
    chk("jizr_br", br_en, 1);
    issue(5'd26, 4'd0, 1);
    chk("mthr_math", math_en, 1);
    issue(5'd31, 4'd2, 1);
    chk("ndne_halted", halted, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    issue(5'd24, 4'd0, 0);
    chk("zzzz_illegal", illegal, 1);
    chk("zzzz_halted", halted, 1);
    chk("zzzz_no_valid", out_valid, 0);
    chk("zzzz_in_ready", in_ready, 0);
    reset = 1;
    tick();
    reset = 0;
    mlit = '0;
    chk("zzzz_rst_illegal", illegal, 0);
`else
    issue(5'd24, 4'd0, 1);
    chk("zzzz_valid", out_valid, 1);
    chk("zzzz_op", op, 24);
    chk("zzzz_en", {mov_en, br_en, math_en, mem_rd, mem_wr}, 0);
    chk("zzzz_illegal", illegal, 0);
`endif
    issue(5'd31, 4'd3, 1);
    chk("done_valid", out_valid, 1);
    chk("done_op", op, 31);
    chk("done_halted", halted, 1);
    out_ready = 0;
    tick();
    chk("done_held", out_valid, 1);
    out_ready = 1;
    instr = {5'd6, 4'd1};
    in_valid = 1;
    tick();
    for (int i = 0; i < 11; i++) begin
      chk("halt_in_ready", in_ready, 0);
      chk("halt_flag", halted, 1);
      chk("halt_no_valid", out_valid, 0);
      tick();
    end
    in_valid = 0;
    reset = 1;
    tick();
    chk("reset_halted", halted, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 0;
    #1;
    chk("after_reset_in_ready", in_ready, 1);
    chk("after_reset_lit", lit_val, 0);
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
